// File: rtl/tdc_hw_accum.sv
// Batch accumulator for TDC Hamming-weight codes: skips SKIP samples, sums 2**LOG_SAMPLES samples.
// Optional min/max trackers are built when TDC_HW_ACCUM_MINMAX_EN is defined.
module tdc_hw_accum #(
    parameter int N           = 64,
    parameter int LOG_SAMPLES = 8,
    parameter int SKIP        = 2,
    localparam int HW_W       = $clog2(N) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [HW_W-1:0]             hw,
    input  logic                        hw_valid,
    output logic                        busy,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [HW_W+LOG_SAMPLES-1:0] res_sum,
    output logic [HW_W-1:0]             res_mean,
    output logic [HW_W-1:0]             res_min,
    output logic [HW_W-1:0]             res_max
);

    localparam int SUM_W  = HW_W + LOG_SAMPLES;
    localparam int CNT_W  = LOG_SAMPLES + 1;
    localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((2 ** LOG_SAMPLES) - 1);

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_ACC, S_HOLD} state_t;

    state_t             state, state_next;
    logic               run_start, acc_take, acc_last;
    logic [SKIP_W-1:0]  skip_cnt;
    logic [CNT_W-1:0]   acc_cnt;
    logic [SUM_W-1:0]   acc_sum, sum_next;

    assign busy      = (state == S_SKIP) || (state == S_ACC);
    assign res_valid = (state == S_HOLD);
    assign sum_next  = acc_sum + SUM_W'(hw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        run_start  = 1'b0;
        acc_take   = 1'b0;
        acc_last   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    run_start  = 1'b1;
                    state_next = (SKIP == 0) ? S_ACC : S_SKIP;
                end
            end
            S_SKIP: begin
                if (abort)                                  state_next = S_IDLE;
                else if (hw_valid && skip_cnt == SKIP_LAST) state_next = S_ACC;
            end
            S_ACC: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (hw_valid) begin
                    acc_take = 1'b1;
                    if (acc_cnt == CNT_LAST) begin
                        acc_last   = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (abort || res_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Counters and sum are cleared on every accepted start; results load only on entry to HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt <= '0;
            acc_cnt  <= '0;
            acc_sum  <= '0;
            res_sum  <= '0;
            res_mean <= '0;
        end else begin
            if (run_start) begin
                skip_cnt <= '0;
                acc_cnt  <= '0;
                acc_sum  <= '0;
            end else begin
                if (state == S_SKIP && hw_valid && !abort)
                    skip_cnt <= skip_cnt + SKIP_W'(1);
                if (acc_take) begin
                    acc_cnt <= acc_cnt + CNT_W'(1);
                    acc_sum <= sum_next;
                end
            end
            if (acc_last) begin
                res_sum  <= sum_next;
                res_mean <= sum_next[SUM_W-1 -: HW_W];
            end
        end
    end

`ifdef TDC_HW_ACCUM_MINMAX_EN
    logic [HW_W-1:0] trk_min, trk_max, min_next, max_next;

    // First accepted sample of a batch seeds both trackers.
    always_comb begin
        min_next = trk_min;
        max_next = trk_max;
        if (acc_cnt == '0 || hw < trk_min) min_next = hw;
        if (acc_cnt == '0 || hw > trk_max) max_next = hw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_min <= '0;
            trk_max <= '0;
            res_min <= '0;
            res_max <= '0;
        end else begin
            if (run_start) begin
                trk_min <= '0;
                trk_max <= '0;
            end else if (acc_take) begin
                trk_min <= min_next;
                trk_max <= max_next;
            end
            if (acc_last) begin
                res_min <= min_next;
                res_max <= max_next;
            end
        end
    end
`else
    assign res_min = '0;
    assign res_max = '0;
`endif

endmodule

// File: tb/tb_tdc_hw_accum.sv
// Bench for tdc_hw_accum: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-based model of the batch measurement.
module tb_tdc_hw_accum;

    localparam int N           = 64;
    localparam int LOG_SAMPLES = 2;
    localparam int SKIP        = 1;
    localparam int HW_W        = $clog2(N) + 1;
    localparam int BATCH       = 2 ** LOG_SAMPLES;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        start, abort, hw_valid, res_ready;
    logic [HW_W-1:0]             hw;
    logic                        busy, res_valid;
    logic [HW_W+LOG_SAMPLES-1:0] res_sum;
    logic [HW_W-1:0]             res_mean, res_min, res_max;

    int n_cmp  = 0;
    int n_fail = 0;

    tdc_hw_accum #(.N(N), .LOG_SAMPLES(LOG_SAMPLES), .SKIP(SKIP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .hw(hw), .hw_valid(hw_valid), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_sum(res_sum), .res_mean(res_mean),
        .res_min(res_min), .res_max(res_max)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 discarding, 2 collecting, 3 result held.
    int          m_phase;
    int          m_skip_left;
    int unsigned m_q[$];
    int unsigned m_sum, m_mean, m_min, m_max;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_skip_left = 0; m_q.delete();
            m_sum = 0; m_mean = 0; m_min = 0; m_max = 0;
        end else begin
            case (m_phase)
                0: if (start && !abort) begin
                    m_q.delete();
                    m_skip_left = SKIP;
                    m_phase = (SKIP > 0) ? 1 : 2;
                end
                1: if (abort) m_phase = 0;
                   else if (hw_valid) begin
                       m_skip_left--;
                       if (m_skip_left == 0) m_phase = 2;
                   end
                2: if (abort) m_phase = 0;
                   else if (hw_valid) begin
                       m_q.push_back(int'(hw));
                       if (m_q.size() == BATCH) begin
                           m_sum = 0; m_min = m_q[0]; m_max = m_q[0];
                           foreach (m_q[i]) begin
                               m_sum += m_q[i];
                               if (m_q[i] < m_min) m_min = m_q[i];
                               if (m_q[i] > m_max) m_max = m_q[i];
                           end
                           m_mean = m_sum / BATCH;
`ifndef TDC_HW_ACCUM_MINMAX_EN
                           m_min = 0; m_max = 0;
`endif
                           m_phase = 3;
                       end
                   end
                3: if (abort || res_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy",  busy,      (m_phase == 1 || m_phase == 2) ? 1 : 0);
        chk("cyc_valid", res_valid, (m_phase == 3) ? 1 : 0);
        chk("cyc_sum",   res_sum,   m_sum);
        chk("cyc_mean",  res_mean,  m_mean);
        chk("cyc_min",   res_min,   m_min);
        chk("cyc_max",   res_max,   m_max);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v);
        hw = HW_W'(v);
        hw_valid = 1'b1;
        cyc();
        hw_valid = 1'b0;
    endtask

    task automatic expect_res(input string nm, input int s, input int mean, input int mn, input int mx);
`ifndef TDC_HW_ACCUM_MINMAX_EN
        mn = 0; mx = 0;
`endif
        chk({nm, "_valid"}, res_valid, 1);
        chk({nm, "_busy"},  busy, 0);
        chk({nm, "_sum"},   res_sum, s);
        chk({nm, "_mean"},  res_mean, mean);
        chk({nm, "_min"},   res_min, mn);
        chk({nm, "_max"},   res_max, mx);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        hw = '0; hw_valid = 1'b0; res_ready = 1'b0;

        // Reset and idle behaviour
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_sum", res_sum, 0);
        cyc();
        rst_n = 1'b1;
        feed(33); feed(5);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", res_valid, 0);

        // Back-to-back batch
        cyc();
        start = 1'b1; cyc(); start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        #6;
        feed(7); feed(10); feed(20); feed(30); feed(40);
        @(negedge clk);
        expect_res("b2b", 100, 25, 10, 40);
        chk("model_pin_sum", m_sum, 100);
        chk("model_pin_mean", m_mean, 25);

        // Stalled consumer, start ignored in HOLD
        #6;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            cyc();
        end
        start = 1'b0;
        @(negedge clk);
        expect_res("hold", 100, 25, 10, 40);
        #6;
        res_ready = 1'b1; cyc(); res_ready = 1'b0;
        @(negedge clk);
        chk("drain_valid", res_valid, 0);
        #6;
        start = 1'b1; cyc(); start = 1'b0;
        @(negedge clk);
        chk("restart_busy", busy, 1);

        // Same samples with idle gaps
        #6;
        feed(7); cyc(); feed(10); cyc(); cyc(); feed(20); cyc(); cyc(); cyc();
        feed(30); cyc(); feed(40);
        @(negedge clk);
        expect_res("gaps", 100, 25, 10, 40);
        #6;
        res_ready = 1'b1; cyc(); res_ready = 1'b0;

        // Abort after two accumulated samples, then a full-scale batch
        start = 1'b1; cyc(); start = 1'b0;
        feed(7); feed(11); feed(12);
        abort = 1'b1; cyc(); abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", res_valid, 0);
        chk("abort_keep_sum", res_sum, 100);
        #6;
        start = 1'b1; cyc(); start = 1'b0;
        feed(7); feed(64); feed(64); feed(64); feed(64);
        @(negedge clk);
        expect_res("full", 256, 64, 64, 64);
        #6;
        res_ready = 1'b1; cyc(); res_ready = 1'b0;

        // Reset in the middle of accumulation
        start = 1'b1; cyc(); start = 1'b0;
        feed(7); feed(3); feed(4);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", res_valid, 0);
        chk("midrst_sum", res_sum, 0);
        chk("midrst_mean", res_mean, 0);
        chk("midrst_max", res_max, 0);
        cyc(); cyc();
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            int r;
            start     = ($urandom % 6) == 0;
            abort     = ($urandom % 50) == 0;
            hw_valid  = ($urandom % 3) != 0;
            res_ready = ($urandom % 3) == 0;
            r = $urandom % 8;
            hw = (r == 0) ? HW_W'(0) : (r == 1) ? HW_W'(N) : HW_W'($urandom_range(0, N));
            cyc();
        end
        start = 1'b0; abort = 1'b0; hw_valid = 1'b0; res_ready = 1'b0;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
